// File: rtl/ucode_checkpoint_monitor.sv
// Microcode checkpoint monitor: watches the execute-stage uPC stream against a
// programmable checkpoint table and reports pass/skip/fail/end events, issues
// skip redirects to the sequencer and runs a cycle-limit watchdog.
//
// state | meaning
// IDLE  | out of reset, waiting for the first arm
// RUN   | matching the execute stream, watchdog counting
// PASS  | end label reached; events suppressed until re-armed
// FAIL  | fail label hit or watchdog expired (timeout tells which)
module ucode_checkpoint_monitor #(
  parameter int PC_W      = 12,
  parameter int N_ENTRIES = 16,
  parameter int LIMIT_W   = 24,
  localparam int IDX_W    = $clog2(N_ENTRIES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               arm,
  input  logic               x_valid,
  input  logic [PC_W-1:0]    x_pc,
  input  logic               x_cont,
  input  logic [PC_W-1:0]    x_target,
  input  logic [PC_W-1:0]    f_pc,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [1:0]         cfg_kind,
  input  logic [PC_W-1:0]    cfg_from,
  input  logic [PC_W-1:0]    cfg_to,
  input  logic [PC_W-1:0]    cfg_tgt,
  input  logic [PC_W-1:0]    end_pc,
  input  logic [LIMIT_W-1:0] limit,
  output logic               redir_valid,
  output logic [PC_W-1:0]    redir_pc,
  output logic               ev_valid,
  output logic [IDX_W-1:0]   ev_idx,
  output logic [1:0]         ev_kind,
  output logic [7:0]         pass_cnt,
  output logic [7:0]         skip_cnt,
  output logic [1:0]         state,
  output logic               timeout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_PASS = 2'd2;
  localparam logic [1:0] S_FAIL = 2'd3;

  localparam logic [1:0] K_PASS = 2'd1;
  localparam logic [1:0] K_SKIP = 2'd2;
  localparam logic [1:0] K_FAIL = 2'd3;

  logic [1:0]         r_kind [N_ENTRIES];
  logic [PC_W-1:0]    r_from [N_ENTRIES];
  logic [PC_W-1:0]    r_to   [N_ENTRIES];
  logic [PC_W-1:0]    r_tgt  [N_ENTRIES];

  logic [1:0]         r_state;
  logic [LIMIT_W-1:0] r_wd;
  logic               r_redir_valid;
  logic [PC_W-1:0]    r_redir_pc;
  logic               r_ev_valid;
  logic [IDX_W-1:0]   r_ev_idx;
  logic [1:0]         r_ev_kind;
  logic [7:0]         r_pass_cnt;
  logic [7:0]         r_skip_cnt;
  logic               r_timeout;

  logic               w_fail_hit, w_skip_hit, w_pass_hit, w_end_hit;
  logic [IDX_W-1:0]   w_fail_idx, w_skip_idx, w_pass_idx;
  logic               w_eval;
  logic               w_wd_hit;

  // Checkpoint table: written any time, kinds cleared on reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        r_kind[i] <= '0;
        r_from[i] <= '0;
        r_to[i]   <= '0;
        r_tgt[i]  <= '0;
      end
    end else if (cfg_we) begin
      r_kind[cfg_idx] <= cfg_kind;
      r_from[cfg_idx] <= cfg_from;
      r_to[cfg_idx]   <= cfg_to;
      r_tgt[cfg_idx]  <= cfg_tgt;
    end
  end

  // Per-kind match search; scanning downward leaves the lowest matching index
  always_comb begin
    w_fail_hit = 1'b0;
    w_skip_hit = 1'b0;
    w_pass_hit = 1'b0;
    w_fail_idx = '0;
    w_skip_idx = '0;
    w_pass_idx = '0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (r_kind[i] == K_FAIL && x_pc == r_from[i]) begin
        w_fail_hit = 1'b1;
        w_fail_idx = IDX_W'(i);
      end
      if (r_kind[i] == K_SKIP && x_pc == r_from[i] && f_pc == r_to[i]) begin
        w_skip_hit = 1'b1;
        w_skip_idx = IDX_W'(i);
      end
      if (r_kind[i] == K_PASS && x_cont && x_target == r_from[i]) begin
        w_pass_hit = 1'b1;
        w_pass_idx = IDX_W'(i);
      end
    end
    w_end_hit = (x_pc == end_pc);
    // The instruction retiring while a redirect is out was fetched down the
    // wrong path, so it is never matched; arm also drops any match.
    w_eval    = (r_state == S_RUN) && x_valid && !r_redir_valid && !arm;
    // Fires on the limit-th x_valid (pre-increment count equals limit-1)
    w_wd_hit  = (r_state == S_RUN) && x_valid && !arm && (limit != '0) &&
                (r_wd == limit - LIMIT_W'(1));
  end

  // Sequencing FSM, event pulses, counters and watchdog
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_wd          <= '0;
      r_redir_valid <= 1'b0;
      r_redir_pc    <= '0;
      r_ev_valid    <= 1'b0;
      r_ev_idx      <= '0;
      r_ev_kind     <= '0;
      r_pass_cnt    <= '0;
      r_skip_cnt    <= '0;
      r_timeout     <= 1'b0;
    end else begin
      r_redir_valid <= 1'b0;
      r_ev_valid    <= 1'b0;
      if (arm) begin
        r_state    <= S_RUN;
        r_wd       <= '0;
        r_pass_cnt <= '0;
        r_skip_cnt <= '0;
        r_timeout  <= 1'b0;
      end else if (r_state == S_RUN) begin
        if (x_valid) r_wd <= r_wd + LIMIT_W'(1);
        if (w_eval && w_fail_hit) begin
          r_ev_valid <= 1'b1;
          r_ev_idx   <= w_fail_idx;
          r_ev_kind  <= K_FAIL;
          r_state    <= S_FAIL;
        end else if (w_eval && w_end_hit) begin
          r_ev_valid <= 1'b1;
          r_ev_idx   <= '0;
          r_ev_kind  <= K_PASS;
          r_state    <= S_PASS;
        end else begin
          if (w_eval && w_skip_hit) begin
            r_ev_valid    <= 1'b1;
            r_ev_idx      <= w_skip_idx;
            r_ev_kind     <= K_SKIP;
            r_redir_valid <= 1'b1;
            r_redir_pc    <= r_tgt[w_skip_idx];
            if (r_skip_cnt != 8'hFF) r_skip_cnt <= r_skip_cnt + 8'd1;
          end else if (w_eval && w_pass_hit) begin
            r_ev_valid <= 1'b1;
            r_ev_idx   <= w_pass_idx;
            r_ev_kind  <= K_PASS;
            if (r_pass_cnt != 8'hFF) r_pass_cnt <= r_pass_cnt + 8'd1;
          end
          if (w_wd_hit) begin
            r_state   <= S_FAIL;
            r_timeout <= 1'b1;
          end
        end
      end
    end
  end

  assign redir_valid = r_redir_valid;
  assign redir_pc    = r_redir_pc;
  assign ev_valid    = r_ev_valid;
  assign ev_idx      = r_ev_idx;
  assign ev_kind     = r_ev_kind;
  assign pass_cnt    = r_pass_cnt;
  assign skip_cnt    = r_skip_cnt;
  assign state       = r_state;
  assign timeout     = r_timeout;

endmodule

// File: tb/tb_ucode_checkpoint_monitor.sv
// Bench for ucode_checkpoint_monitor: directed vector table, directed
// watchdog/end/saturation/reset sequences and a randomized run against a
// behavioural model.
module tb_ucode_checkpoint_monitor;

  localparam int PC_W = 12;
  localparam int N    = 16;
  localparam int LW   = 24;

  logic            clk = 1'b0;
  logic            reset;
  logic            arm;
  logic            x_valid;
  logic [PC_W-1:0] x_pc;
  logic            x_cont;
  logic [PC_W-1:0] x_target;
  logic [PC_W-1:0] f_pc;
  logic            cfg_we;
  logic [3:0]      cfg_idx;
  logic [1:0]      cfg_kind;
  logic [PC_W-1:0] cfg_from, cfg_to, cfg_tgt;
  logic [PC_W-1:0] end_pc;
  logic [LW-1:0]   limit;
  logic            redir_valid;
  logic [PC_W-1:0] redir_pc;
  logic            ev_valid;
  logic [3:0]      ev_idx;
  logic [1:0]      ev_kind;
  logic [7:0]      pass_cnt, skip_cnt;
  logic [1:0]      state;
  logic            timeout;

  ucode_checkpoint_monitor #(.PC_W(PC_W), .N_ENTRIES(N), .LIMIT_W(LW)) dut (
    .clk(clk), .reset(reset), .arm(arm), .x_valid(x_valid), .x_pc(x_pc),
    .x_cont(x_cont), .x_target(x_target), .f_pc(f_pc), .cfg_we(cfg_we),
    .cfg_idx(cfg_idx), .cfg_kind(cfg_kind), .cfg_from(cfg_from),
    .cfg_to(cfg_to), .cfg_tgt(cfg_tgt), .end_pc(end_pc), .limit(limit),
    .redir_valid(redir_valid), .redir_pc(redir_pc), .ev_valid(ev_valid),
    .ev_idx(ev_idx), .ev_kind(ev_kind), .pass_cnt(pass_cnt),
    .skip_cnt(skip_cnt), .state(state), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- behavioural reference model ----------------
  int m_kind [N];
  int m_from [N];
  int m_to   [N];
  int m_tgt  [N];
  int m_state, m_pass, m_skip, m_to_flag;
  int m_rv, m_rpc, m_ev, m_eidx, m_ekind;
  longint m_xcnt;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_kind[i] = 0; m_from[i] = 0; m_to[i] = 0; m_tgt[i] = 0;
    end
    m_state = 0; m_pass = 0; m_skip = 0; m_to_flag = 0;
    m_rv = 0; m_rpc = 0; m_ev = 0; m_eidx = 0; m_ekind = 0; m_xcnt = 0;
  endtask

  // Returns 3 fail, 4 end, 2 skip, 1 pass, 0 nothing, in priority order
  task automatic classify(output int k, output int ix);
    k = 0; ix = 0;
    for (int i = 0; i < N; i++)
      if (k == 0 && m_kind[i] == 3 && int'(x_pc) == m_from[i]) begin k = 3; ix = i; end
    if (k == 0 && x_pc == end_pc) k = 4;
    for (int i = 0; i < N; i++)
      if (k == 0 && m_kind[i] == 2 && int'(x_pc) == m_from[i] && int'(f_pc) == m_to[i]) begin
        k = 2; ix = i;
      end
    for (int i = 0; i < N; i++)
      if (k == 0 && m_kind[i] == 1 && x_cont && int'(x_target) == m_from[i]) begin
        k = 1; ix = i;
      end
  endtask

  task automatic model_step();
    int  k, ix;
    bit  timed;
    int  squashing;
    squashing = m_rv;
    m_rv = 0;
    m_ev = 0;
    if (arm) begin
      m_state = 1; m_pass = 0; m_skip = 0; m_xcnt = 0; m_to_flag = 0;
    end else if (m_state == 1) begin
      k = 0; ix = 0;
      if (x_valid && squashing == 0) classify(k, ix);
      timed = x_valid && limit != 0 && (m_xcnt + 1 == longint'(limit));
      if (x_valid) m_xcnt++;
      if (k == 3) begin
        m_ev = 1; m_eidx = ix; m_ekind = 3; m_state = 3;
      end else if (k == 4) begin
        m_ev = 1; m_eidx = 0; m_ekind = 1; m_state = 2;
      end else begin
        if (k == 2) begin
          m_ev = 1; m_eidx = ix; m_ekind = 2; m_rv = 1; m_rpc = m_tgt[ix];
          if (m_skip < 255) m_skip++;
        end else if (k == 1) begin
          m_ev = 1; m_eidx = ix; m_ekind = 1;
          if (m_pass < 255) m_pass++;
        end
        if (timed) begin m_state = 3; m_to_flag = 1; end
      end
    end
    if (cfg_we) begin
      m_kind[cfg_idx] = cfg_kind; m_from[cfg_idx] = cfg_from;
      m_to[cfg_idx] = cfg_to; m_tgt[cfg_idx] = cfg_tgt;
    end
  endtask

  // ---------------- helpers ----------------
  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(string tag);
    chk({tag, " state"}, state, m_state);
    chk({tag, " pass_cnt"}, pass_cnt, m_pass);
    chk({tag, " skip_cnt"}, skip_cnt, m_skip);
    chk({tag, " timeout"}, timeout, m_to_flag);
    chk({tag, " ev_valid"}, ev_valid, m_ev);
    chk({tag, " redir_valid"}, redir_valid, m_rv);
    if (m_ev != 0) begin
      chk({tag, " ev_idx"}, ev_idx, m_eidx);
      chk({tag, " ev_kind"}, ev_kind, m_ekind);
    end
    if (m_rv != 0) chk({tag, " redir_pc"}, redir_pc, m_rpc);
  endtask

  task automatic tick();
    if (!reset) model_reset(); else model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    arm = 0; x_valid = 0; x_pc = 0; x_cont = 0; x_target = 0; f_pc = 0;
    cfg_we = 0; cfg_idx = 0; cfg_kind = 0; cfg_from = 0; cfg_to = 0; cfg_tgt = 0;
  endtask

  task automatic cfg_write(int idx, int kind, int from, int to, int tgt);
    idle_inputs();
    cfg_we = 1; cfg_idx = 4'(idx); cfg_kind = 2'(kind);
    cfg_from = PC_W'(from); cfg_to = PC_W'(to); cfg_tgt = PC_W'(tgt);
    tick();
    cfg_we = 0;
  endtask

  typedef struct {
    bit arm, xv, xcont;
    int xpc, xtgt, fpc;
    bit ev_v; int ev_idx, ev_kind;
    bit rd_v; int rd_pc;
    int st, pc, sc;
    bit to;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(bit a, bit xv, int xpc, bit xc, int xt, int fp,
                              bit ev, int ei, int ek, bit rv, int rp,
                              int st, int pc, int sc, bit to);
    vec_t v;
    v.arm = a; v.xv = xv; v.xpc = xpc; v.xcont = xc; v.xtgt = xt; v.fpc = fp;
    v.ev_v = ev; v.ev_idx = ei; v.ev_kind = ek; v.rd_v = rv; v.rd_pc = rp;
    v.st = st; v.pc = pc; v.sc = sc; v.to = to;
    return v;
  endfunction

  initial begin
    //            arm xv  xpc  xc xtgt  fpc  ev ei ek rv rpc st pc sc to
    vecs[0]  = mk(0, 1, 100,  1, 12,   0,   1, 0, 1, 0, 0,  1, 1, 0, 0);
    vecs[1]  = mk(0, 0, 0,    0, 0,    0,   0, 0, 0, 0, 0,  1, 1, 0, 0);
    vecs[2]  = mk(0, 1, 43,   0, 0,    44,  1, 3, 2, 1, 53, 1, 1, 1, 0);
    vecs[3]  = mk(0, 1, 1666, 0, 0,    0,   0, 0, 0, 0, 0,  1, 1, 1, 0);
    vecs[4]  = mk(0, 1, 43,   0, 0,    99,  0, 0, 0, 0, 0,  1, 1, 1, 0);
    vecs[5]  = mk(0, 1, 1666, 1, 1666, 0,   1, 5, 3, 0, 0,  3, 1, 1, 0);
    vecs[6]  = mk(0, 1, 100,  1, 12,   0,   0, 0, 0, 0, 0,  3, 1, 1, 0);
    vecs[7]  = mk(1, 0, 0,    0, 0,    0,   0, 0, 0, 0, 0,  1, 0, 0, 0);
    vecs[8]  = mk(0, 1, 1564, 1, 12,   0,   1, 0, 1, 0, 0,  2, 0, 0, 0);
    vecs[9]  = mk(0, 1, 1666, 0, 0,    0,   0, 0, 0, 0, 0,  2, 0, 0, 0);
    vecs[10] = mk(1, 1, 100,  1, 12,   0,   0, 0, 0, 0, 0,  1, 0, 0, 0);
    vecs[11] = mk(0, 1, 43,   1, 12,   44,  1, 3, 2, 1, 53, 1, 0, 1, 0);
    vecs[12] = mk(0, 0, 0,    0, 0,    0,   0, 0, 0, 0, 0,  1, 0, 1, 0);

    idle_inputs();
    end_pc = 12'd1564;
    limit  = '0;
    reset  = 0;
    model_reset();
    tick();
    tick();
    chk("reset state", state, 0);
    chk("reset ev_valid", ev_valid, 0);
    chk("reset redir_valid", redir_valid, 0);
    chk("reset timeout", timeout, 0);
    chk("reset pass_cnt", pass_cnt, 0);
    reset = 1;
    tick();

    // Table: duplicates check lowest-index priority within a kind
    cfg_write(0, 1, 12,   0,  0);
    cfg_write(2, 1, 12,   0,  0);
    cfg_write(3, 2, 43,   44, 53);
    cfg_write(5, 3, 1666, 0,  0);
    cfg_write(7, 3, 1666, 0,  0);
    cfg_write(1, 1, 1666, 0,  0);
    chk("idle after cfg", state, 0);
    idle_inputs(); arm = 1; tick(); arm = 0;
    chk("arm to run", state, 1);

    for (int i = 0; i < 13; i++) begin
      idle_inputs();
      arm = vecs[i].arm; x_valid = vecs[i].xv; x_pc = PC_W'(vecs[i].xpc);
      x_cont = vecs[i].xcont; x_target = PC_W'(vecs[i].xtgt); f_pc = PC_W'(vecs[i].fpc);
      tick();
      chk($sformatf("vec%0d ev_valid", i), ev_valid, vecs[i].ev_v);
      if (vecs[i].ev_v) begin
        chk($sformatf("vec%0d ev_idx", i), ev_idx, vecs[i].ev_idx);
        chk($sformatf("vec%0d ev_kind", i), ev_kind, vecs[i].ev_kind);
      end
      chk($sformatf("vec%0d redir_valid", i), redir_valid, vecs[i].rd_v);
      if (vecs[i].rd_v) chk($sformatf("vec%0d redir_pc", i), redir_pc, vecs[i].rd_pc);
      chk($sformatf("vec%0d state", i), state, vecs[i].st);
      chk($sformatf("vec%0d pass_cnt", i), pass_cnt, vecs[i].pc);
      chk($sformatf("vec%0d skip_cnt", i), skip_cnt, vecs[i].sc);
      chk($sformatf("vec%0d timeout", i), timeout, vecs[i].to);
    end

    // End label after a long non-matching run, watchdog disabled
    idle_inputs(); arm = 1; tick();
    for (int i = 0; i < 300; i++) begin
      idle_inputs(); x_valid = 1; x_pc = PC_W'(200 + (i % 800)); tick();
    end
    chk("long run state", state, 1);
    chk("long run no event", ev_valid, 0);
    idle_inputs(); x_valid = 1; x_pc = 12'd1564; tick();
    chk("end state", state, 2);
    chk("end ev_valid", ev_valid, 1);
    chk("end ev_kind", ev_kind, 1);
    chk("end ev_idx", ev_idx, 0);
    idle_inputs(); x_valid = 1; x_pc = 12'd1666; x_cont = 1; x_target = 12'd12; tick();
    chk("after pass no event", ev_valid, 0);
    chk("after pass state", state, 2);

    // Watchdog expiry on the 100th x_valid
    limit = 24'd100;
    idle_inputs(); arm = 1; tick();
    for (int i = 0; i < 99; i++) begin
      idle_inputs(); x_valid = 1; x_pc = PC_W'(300 + i); tick();
      if (i % 3 == 0) begin idle_inputs(); tick(); end
    end
    chk("wd 99 state", state, 1);
    chk("wd 99 timeout", timeout, 0);
    idle_inputs(); x_valid = 1; x_pc = 12'd500; tick();
    chk("wd 100 state", state, 3);
    chk("wd 100 timeout", timeout, 1);
    chk("wd no event", ev_valid, 0);
    limit = '0;
    idle_inputs(); arm = 1; tick();
    chk("rearm state", state, 1);
    chk("rearm timeout", timeout, 0);
    chk("rearm pass_cnt", pass_cnt, 0);
    chk("rearm skip_cnt", skip_cnt, 0);
    idle_inputs(); x_valid = 1; x_pc = 12'd100; x_cont = 1; x_target = 12'd12; tick();
    chk("table kept ev", ev_valid, 1);
    chk("table kept idx", ev_idx, 0);
    idle_inputs(); x_valid = 1; x_pc = 12'd43; f_pc = 12'd44; tick();
    chk("table kept redir", redir_valid, 1);
    chk("table kept redir_pc", redir_pc, 53);

    // Pass counter saturation, then reset mid-stream
    idle_inputs(); arm = 1; tick();
    for (int i = 0; i < 300; i++) begin
      idle_inputs(); x_valid = 1; x_pc = 12'd100; x_cont = 1; x_target = 12'd12; tick();
    end
    chk("pass saturate", pass_cnt, 255);
    chk("pass sat ev", ev_valid, 1);
    #2;
    reset = 0;
    #1;
    chk("async rst state", state, 0);
    chk("async rst ev_valid", ev_valid, 0);
    chk("async rst pass_cnt", pass_cnt, 0);
    chk("async rst skip_cnt", skip_cnt, 0);
    chk("async rst redir_pc", redir_pc, 0);
    chk("async rst ev_idx", ev_idx, 0);
    chk("async rst ev_kind", ev_kind, 0);
    idle_inputs();
    tick();
    reset = 1;
    tick();
    check_model("post reset");

    // Randomized run against the model on a small PC space
    end_pc = 12'd9;
    limit  = 24'd30;
    for (int i = 0; i < 16; i++)
      cfg_write(i, $urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 15),
                $urandom_range(0, 4095));
    for (int c = 0; c < 3000; c++) begin
      arm      = ($urandom_range(0, 39) == 0);
      x_valid  = ($urandom_range(0, 3) != 0);
      x_pc     = PC_W'($urandom_range(0, 15));
      x_cont   = 1'($urandom_range(0, 1));
      x_target = PC_W'($urandom_range(0, 15));
      f_pc     = PC_W'($urandom_range(0, 15));
      cfg_we   = ($urandom_range(0, 15) == 0);
      cfg_idx  = 4'($urandom_range(0, 15));
      cfg_kind = 2'($urandom_range(0, 3));
      cfg_from = PC_W'($urandom_range(0, 15));
      cfg_to   = PC_W'($urandom_range(0, 15));
      cfg_tgt  = PC_W'($urandom_range(0, 4095));
      tick();
      check_model($sformatf("rand%0d", c));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
